// File: rtl/disp_scan_ctrl.sv
// Refresh/scan controller for an 8-digit seven-segment display: digit select, active-low anodes,
// per-slot blanking and a frame-buffered nibble source. Optional anode PWM under DISP_SCAN_PWM_EN.
module disp_scan_ctrl #(
    parameter int CLK_DIV      = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [7:0]  digit_en,
    output logic [2:0]  sel,
    output logic [7:0]  an,
    output logic [3:0]  nibble,
    output logic        frame_done
`ifdef DISP_SCAN_PWM_EN
    ,
    input  logic [3:0]  bright
`endif
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    // Handshake: a frame transfers on any rising edge where data_valid && data_ready are both high;
    // data_ready is low exactly while the pending buffer holds a frame not yet promoted to active.
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       sel_nxt;
    logic [31:0]      pending, active, active_nxt;
    phase_t           phase, phase_nxt;
    logic             last_cnt, wrap, take, lit;
    logic [7:0]       an_nxt;
`ifdef DISP_SCAN_PWM_EN
    logic [3:0]       pwm, pwm_nxt;
`endif

    always_comb begin
        last_cnt   = (cnt == CNT_W'(CLK_DIV - 1));
        wrap       = last_cnt && (sel == 3'd7);
        cnt_nxt    = last_cnt ? '0 : cnt + 1'b1;
        sel_nxt    = last_cnt ? sel + 3'd1 : sel;
        take       = data_valid && data_ready;
        // Promotion only at the frame boundary keeps a frame from tearing mid-scan.
        active_nxt = (wrap && !data_ready) ? pending : active;

        if (cnt_nxt == CNT_W'(BLANK_CYCLES))
            phase_nxt = PH_SHOW;
        else if (last_cnt)
            phase_nxt = PH_BLANK;
        else
            phase_nxt = phase;

`ifdef DISP_SCAN_PWM_EN
        pwm_nxt = pwm + 4'd1;
        lit     = (pwm_nxt <= bright);
`else
        lit     = 1'b1;
`endif

        // Outputs are registered from next-state values so an/sel/nibble always describe the same slot.
        if (phase_nxt == PH_SHOW && digit_en[sel_nxt] && lit)
            an_nxt = ~(8'd1 << sel_nxt);
        else
            an_nxt = 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= 3'd0;
            phase      <= PH_BLANK;
            an         <= 8'hFF;
            nibble     <= 4'd0;
            active     <= 32'd0;
            pending    <= 32'd0;
            data_ready <= 1'b1;
            frame_done <= 1'b0;
`ifdef DISP_SCAN_PWM_EN
            pwm        <= 4'd0;
`endif
        end else begin
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            phase      <= phase_nxt;
            an         <= an_nxt;
            active     <= active_nxt;
            nibble     <= active_nxt[{sel_nxt, 2'b00} +: 4];
            frame_done <= wrap;
`ifdef DISP_SCAN_PWM_EN
            pwm        <= pwm_nxt;
`endif
            // take needs data_ready high and promotion needs it low, so they never coincide.
            if (take) begin
                pending    <= data_in;
                data_ready <= 1'b0;
            end else if (wrap && !data_ready) begin
                data_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (CLK_DIV=8, BLANK_CYCLES=2); a CLK_DIV=64 instance
// exercises the brightness PWM when DISP_SCAN_PWM_EN is defined.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  digit_en;
    logic [2:0]  sel;
    logic [7:0]  an;
    logic [3:0]  nibble;
    logic        frame_done;

    int n_checks;
    int n_errors;
    int cnt_m;
    int sel_m;

    disp_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .digit_en   (digit_en),
        .sel        (sel),
        .an         (an),
        .nibble     (nibble),
        .frame_done (frame_done)
`ifdef DISP_SCAN_PWM_EN
        ,
        .bright     (4'd15)
`endif
    );

`ifdef DISP_SCAN_PWM_EN
    logic       ready2;
    logic [2:0] sel2;
    logic [7:0] an2;
    logic [3:0] nibble2;
    logic       done2;

    disp_scan_ctrl #(.CLK_DIV(64), .BLANK_CYCLES(2)) dut_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (32'd0),
        .data_valid (1'b0),
        .data_ready (ready2),
        .digit_en   (8'hFF),
        .sel        (sel2),
        .an         (an2),
        .nibble     (nibble2),
        .frame_done (done2),
        .bright     (4'd3)
    );
`endif

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (sel_m=%0d cnt_m=%0d)", tag, got, exp, sel_m, cnt_m);
        end
    endtask

    // one clock edge, then settle; track slot position independently of the DUT
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (cnt_m == 7) begin
                cnt_m = 0;
                sel_m = (sel_m + 1) % 8;
            end else begin
                cnt_m++;
            end
        end
    endtask

    task automatic tick_until(input int s, input int c);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(sel_m == s && cnt_m == c) && n < 200);
        if (n >= 200) check("wait_bound", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [31:0] d);
        data_in    = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    function automatic logic [7:0] an_exp(input int s, input int c, input logic [7:0] en);
        logic [7:0] one;
        one = 8'd1;
        if (c < 2 || !en[s]) return 8'hFF;
        return ~(one << s);
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cnt_m      = 0;
        sel_m      = 0;
        rst_n      = 1'b0;
        data_in    = 32'd0;
        data_valid = 1'b0;
        digit_en   = 8'hFF;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 8'hFF);
        check("rst_sel", sel, 3'd0);
        check("rst_nibble", nibble, 4'd0);
        check("rst_ready", data_ready, 1'b1);
        check("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;

        // first slot after release: blank then show, sel steps at cycle 8
        tick();
        check("s0_c1_an", an, 8'hFF);
        check("s0_c1_done", frame_done, 1'b0);
        tick();
        check("s0_c2_an", an, 8'hFE);
        repeat (5) tick();
        check("s0_c7_sel", sel, 3'd0);
        tick();
        check("s1_c0_sel", sel, 3'd1);
        check("s1_c0_an", an, 8'hFF);

        // frame load and full scan
        send(32'h76543210);
        check("load_ready_low", data_ready, 1'b0);
        check("load_no_done", frame_done, 1'b0);
        check("load_nibble_old", nibble, 4'd0);
        tick_until(0, 0);
        check("wrap_done", frame_done, 1'b1);
        check("wrap_ready", data_ready, 1'b1);
        for (int i = 0; i < 64; i++) begin
            check("scan_sel", sel, sel_m);
            check("scan_nibble", nibble, sel_m);
            check("scan_an", an, an_exp(sel_m, cnt_m, 8'hFF));
            check("scan_done", frame_done, (sel_m == 0 && cnt_m == 0));
            tick();
        end

        // partial digit mask: slots 4..7 dark, period unchanged
        digit_en = 8'h0F;
        for (int i = 0; i < 64; i++) begin
            check("mask_sel", sel, sel_m);
            check("mask_an", an, an_exp(sel_m, cnt_m, 8'h0F));
            check("mask_done", frame_done, (sel_m == 0 && cnt_m == 0));
            tick();
        end
        check("mask_period_done", frame_done, 1'b1);
        digit_en = 8'hFF;

        // second offer while pending full is ignored
        send(32'h11111111);
        check("ign_ready_low", data_ready, 1'b0);
        tick();
        tick();
        data_in    = 32'h22222222;
        data_valid = 1'b1;
        repeat (4) tick();
        check("ign_ready_still_low", data_ready, 1'b0);
        data_valid = 1'b0;
        tick_until(0, 0);
        check("ign_ready_back", data_ready, 1'b1);
        for (int i = 0; i < 64; i++) begin
            check("ign_nibble", nibble, 4'd1);
            check("ign_ready", data_ready, 1'b1);
            tick();
        end

        // async reset mid-slot discards active and pending
        send(32'h22222222);
        check("pre_rst_ready", data_ready, 1'b0);
        tick_until(5, 4);
        check("pre_rst_an", an, 8'hDF);
        check("pre_rst_nibble", nibble, 4'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_an", an, 8'hFF);
        check("arst_sel", sel, 3'd0);
        check("arst_nibble", nibble, 4'd0);
        check("arst_ready", data_ready, 1'b1);
        cnt_m = 0;
        sel_m = 0;
        tick();
        rst_n = 1'b1;
        tick_until(0, 0);
        check("post_rst_done", frame_done, 1'b1);
        check("post_rst_nibble", nibble, 4'd0);
        check("post_rst_ready", data_ready, 1'b1);

        // capture coinciding with the wrap edge displays one frame later
        tick_until(7, 7);
        send(32'hFEDCBA98);
        check("wcap_done", frame_done, 1'b1);
        check("wcap_nibble_old", nibble, 4'd0);
        check("wcap_ready_low", data_ready, 1'b0);
        tick_until(0, 0);
        check("wcap_ready_back", data_ready, 1'b1);
        check("wcap_nibble0", nibble, 4'h8);
        repeat (3) tick();
        check("wcap_an0", an, 8'hFE);
        tick_until(1, 0);
        check("wcap_nibble1", nibble, 4'h9);

`ifdef DISP_SCAN_PWM_EN
        begin
            int lows;
            lows = 0;
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            cnt_m = 0;
            sel_m = 0;
            // CLK_DIV=64 instance: cycle k after release has cnt=k and pwm=k%16
            repeat (16) tick();
            for (int i = 0; i < 16; i++) begin
                check("pwm_an", an2, (i <= 3) ? 8'hFE : 8'hFF);
                if (an2[0] == 1'b0) lows++;
                tick();
            end
            check("pwm_low_count", lows, 4);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
